ndigit_bcd_counter: RTL and testbench
=====================================

NDIGIT_BCD_COUNTER -- requirements
Module: ndigit_bcd_counter

Interface
REQ-001 Parameter: N, default 3, number of BCD decades; legal range 1..8.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: enable  input  1  count enable; sampled on clk rising edge.
REQ-005 Port: q  output  4*N  counter value; q[4i+3:4i] = decade i, decade 0 least significant.
REQ-006 Port: done  output  1  terminal-count flag.

Function
REQ-007 The block SHALL be a synchronous N-decade BCD up-counter; every decade SHALL hold only values 0..9.
REQ-008 When enable=1 at a clk rising edge, decade 0 SHALL increment by 1; a decade at 9 SHALL wrap to 0.
REQ-009 Decade i (i>0) SHALL increment on a rising edge only when enable=1 and all decades 0..i-1 equal 9 (ripple-carry condition evaluated combinationally from the current count, no extra latency).
REQ-010 When enable=0 the count SHALL hold its value.
REQ-011 q SHALL be driven directly from registers (no combinational path from enable to q).
REQ-012 done SHALL be combinational: done = enable AND (all decades = 9).
REQ-013 At all-nines with enable=1, the next rising edge SHALL wrap the whole count to 0; done SHALL then deassert.
REQ-014 The count SHALL wrap freely and SHALL NOT saturate or stop at all-nines.
REQ-015 A decade register holding 10..15 (unreachable in normal operation) SHALL load 0 on its next increment.
REQ-016 The increment from count k to k+1 SHALL take exactly one enabled clock edge; full period = 10^N enabled edges.

Reset
REQ-017 reset_n=0 SHALL immediately clear all decades to 0, independent of clk.
REQ-018 During reset, q SHALL be 0 and done SHALL be 0.
REQ-019 Reset asserted mid-count SHALL discard the current count; counting SHALL resume from 0 on the first enabled edge after reset_n returns high.

Structure
REQ-020 A shared package SHALL hold constants: BCD digit width (4) and BCD maximum value (9).
REQ-021 One sub-module, bcd_digit_counter, SHALL implement a single decade: inputs clk, reset_n, inc; outputs 4-bit value and terminal flag (value = 9).
REQ-022 The top SHALL instantiate N bcd_digit_counter instances in a generate loop; inc of decade i = enable AND terminal flags of decades 0..i-1.
REQ-023 done SHALL be derived from enable AND the terminal flag of every decade.

Verification (N=3)
REQ-024 Reset asserted, enable=0 -> q=000, done=0; with reset_n released and enable=0 for 10 edges -> q stays 000.
REQ-025 Reset released, enable=1 for 9 edges -> q=009; 10th edge -> q=010; after 99 edges -> q=099; 100th edge -> q=100.
REQ-026 enable=1 for 999 edges -> q=999, done=1; 1000th edge -> q=000, done=0.
REQ-027 At q=999 drive enable=0 -> done=0, q holds 999 over 5 edges; enable=1 -> done=1 immediately.
REQ-028 At q=457 drive reset_n=0 between clock edges -> q=000 before next edge; release -> counting resumes 001, 002.
REQ-029 Check every cycle that each decade of q is in 0..9 and that q changes only on rising clk edges or reset.

Source files
------------

// File: rtl/ndigit_bcd_counter_pkg.sv
// Shared constants and helpers for the N-decade BCD counter.
//   BcdWidth : bits per BCD decade
//   BcdMax   : largest legal decade value
//   bcd_next : value a decade takes on an increment (codes 9..15 fold back to 0)
package ndigit_bcd_counter_pkg;

   localparam int unsigned BcdWidth = 4;
   localparam logic [BcdWidth-1:0] BcdMax = 4'd9;

   typedef logic [BcdWidth-1:0] bcd_t;

   // Any code at or above 9 wraps to 0, which also recovers illegal codes 10..15.
   function automatic bcd_t bcd_next(input bcd_t value);
      bcd_t result;
      if (value >= BcdMax) begin
         result = '0;
      end else begin
         result = value + 4'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/ndigit_bcd_counter_digit.sv
// Single BCD decade counter.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset, clears the decade
//   inc      : advance the decade by one on the next rising edge
//   value    : registered decade value (0..9)
//   terminal : high while value equals 9
module bcd_digit_counter
   import ndigit_bcd_counter_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                inc,
   output logic [BcdWidth-1:0] value,
   output logic                terminal
);

   bcd_t value_q;
   bcd_t value_d;

   always_comb begin
      value_d = value_q;
      if (inc) begin
         value_d = bcd_next(value_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value    = value_q;
   assign terminal = (value_q == BcdMax);

endmodule

// File: rtl/ndigit_bcd_counter.sv
// N-decade synchronous BCD up-counter with ripple-carry enables.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears every decade
//   enable  : count enable, sampled on the rising edge
//   q       : count value, decade i at q[4i+3:4i], decade 0 least significant
//   done    : combinational terminal count, enable AND all decades at 9
module ndigit_bcd_counter
   import ndigit_bcd_counter_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   output logic [BcdWidth*N-1:0] q,
   output logic                  done
);

   // carry[i] is the increment request for decade i; carry[N] is the overall terminal count.
   logic [N:0]   carry;
   logic [N-1:0] terminal;

   assign carry[0] = enable;

   for (genvar i = 0; i < N; i++) begin : g_decade
      bcd_digit_counter u_digit (
         .clk      (clk),
         .reset_n  (reset_n),
         .inc      (carry[i]),
         .value    (q[BcdWidth*i +: BcdWidth]),
         .terminal (terminal[i])
      );

      assign carry[i+1] = carry[i] & terminal[i];
   end

   // During reset every decade reads 0, so terminal flags and done are low.
   assign done = carry[N];

endmodule

// File: tb/tb_ndigit_bcd_counter.sv
module tb_ndigit_bcd_counter;

   localparam int N   = 3;
   localparam int W   = 4 * N;
   localparam int Mod = 10 ** N;

   logic         clk;
   logic         reset_n;
   logic         enable;
   logic [W-1:0] q;
   logic         done;

   int vectors;
   int miscompares;
   int model_cnt;

   ndigit_bcd_counter #(.N(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .q       (q),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal integer to packed BCD.
   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           rest;
      r    = '0;
      rest = v;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(rest % 10);
         rest        = rest / 10;
      end
      return r;
   endfunction

   function automatic logic model_done();
      return enable && (model_cnt == Mod - 1);
   endfunction

   // Apply n rising edges, advancing the model on each enabled one; returns 1 ns after the last.
   task automatic run_edges(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (reset_n && enable) model_cnt = (model_cnt + 1) % Mod;
      end
      #1;
   endtask

   // Background monitor: decades legal, q stable between edges unless reset intervenes.
   logic [W-1:0] q_after_edge;
   logic         rst_seen;
   initial rst_seen = 1'b0;

   always @(negedge reset_n) rst_seen = 1'b1;

   always @(posedge clk) begin
      #2;
      q_after_edge = q;
      rst_seen     = 1'b0;
   end

   always @(negedge clk) begin
      if ($time > 10) begin
         vectors++;
         if (!rst_seen && q !== q_after_edge) begin
            miscompares++;
            $display("FAIL q_stable: q=%h changed between edges, required %h", q, q_after_edge);
         end
         for (int i = 0; i < N; i++) begin
            vectors++;
            if (q[4*i +: 4] > 4'd9) begin
               miscompares++;
               $display("FAIL digit_range: decade %0d = %0d, required 0..9", i, q[4*i +: 4]);
            end
         end
      end
   end

   task automatic test_reset();
      reset_n   = 1'b0;
      enable    = 1'b0;
      model_cnt = 0;
      #1;
      vectors++;
      if (q !== '0) begin
         miscompares++;
         $display("FAIL reset_q: q=%h required %h", q, {W{1'b0}});
      end
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_done: done=%b required 0", done);
      end
      enable = 1'b1;
      run_edges(3);
      vectors++;
      if (q !== '0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold_enabled: q=%h done=%b required 000 0", q, done);
      end
      enable  = 1'b0;
      reset_n = 1'b1;
      run_edges(10);
      vectors++;
      if (q !== 12'h000) begin
         miscompares++;
         $display("FAIL disabled_hold: q=%h required 000", q);
      end
   endtask

   task automatic test_count_sequence();
      enable = 1'b1;
      run_edges(9);
      vectors++;
      if (q !== 12'h009) begin
         miscompares++;
         $display("FAIL count_9: q=%h required 009", q);
      end
      run_edges(1);
      vectors++;
      if (q !== 12'h010) begin
         miscompares++;
         $display("FAIL count_10: q=%h required 010", q);
      end
      run_edges(89);
      vectors++;
      if (q !== 12'h099) begin
         miscompares++;
         $display("FAIL count_99: q=%h required 099", q);
      end
      run_edges(1);
      vectors++;
      if (q !== 12'h100) begin
         miscompares++;
         $display("FAIL count_100: q=%h required 100", q);
      end
      run_edges(899);
      vectors++;
      if (q !== 12'h999 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL count_999: q=%h done=%b required 999 1", q, done);
      end
      run_edges(1);
      vectors++;
      if (q !== 12'h000 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_1000: q=%h done=%b required 000 0", q, done);
      end
   endtask

   task automatic test_done_hold();
      enable = 1'b1;
      run_edges(Mod - 1);
      enable = 1'b0;
      #1;
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL done_disabled: done=%b required 0", done);
      end
      run_edges(5);
      vectors++;
      if (q !== 12'h999) begin
         miscompares++;
         $display("FAIL hold_999: q=%h required 999", q);
      end
      enable = 1'b1;
      #1;
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL done_reenabled: done=%b required 1", done);
      end
      run_edges(1);
      vectors++;
      if (q !== to_bcd(model_cnt) || q !== 12'h000) begin
         miscompares++;
         $display("FAIL wrap_after_hold: q=%h required 000", q);
      end
   endtask

   task automatic test_reset_mid_count();
      enable = 1'b1;
      run_edges(457);
      vectors++;
      if (q !== 12'h457) begin
         miscompares++;
         $display("FAIL reach_457: q=%h required 457", q);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (q !== 12'h000 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: q=%h done=%b required 000 0", q, done);
      end
      #1;
      reset_n   = 1'b1;
      model_cnt = 0;
      run_edges(1);
      vectors++;
      if (q !== 12'h001) begin
         miscompares++;
         $display("FAIL resume_1: q=%h required 001", q);
      end
      run_edges(1);
      vectors++;
      if (q !== 12'h002) begin
         miscompares++;
         $display("FAIL resume_2: q=%h required 002", q);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         enable = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            #1;
            model_cnt = 0;
            vectors++;
            if (q !== '0 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL rand_reset: q=%h done=%b required 000 0", q, done);
            end
            reset_n = 1'b1;
         end
         #1;
         vectors++;
         if (done !== model_done()) begin
            miscompares++;
            $display("FAIL rand_done: cycle %0d done=%b required %b", c, done, model_done());
         end
         run_edges(1);
         vectors++;
         if (q !== to_bcd(model_cnt)) begin
            miscompares++;
            $display("FAIL rand_q: cycle %0d q=%h required %h", c, q, to_bcd(model_cnt));
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_count_sequence();
      test_done_hold();
      test_reset_mid_count();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
